// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Definitions shared by the multi-cycle data-memory responder and its
// storage array.
//   dmem_state_t          : responder FSM state (IDLE, BUSY, DONE)
//   DMEM_LATENCY_DEFAULT  : default number of BUSY cycles per access
//   DMEM_DEPTH_DEFAULT    : default number of words in the array
//   dmem_cnt_width()      : width of the latency down-counter
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam int unsigned DMEM_LATENCY_DEFAULT = 4;
   localparam int unsigned DMEM_DEPTH_DEFAULT   = 32;

   // The counter must hold LATENCY-1; a latency of 1 still needs a 1-bit counter.
   function automatic int unsigned dmem_cnt_width(input int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Word-wide storage of DEPTH x DATA_W with a synchronous write port and a
// combinational read port sharing one index. Contents are not reset.
//   clk_i    : clock, writes take effect on the rising edge
//   i_we     : write enable
//   i_idx    : word index for both read and write
//   i_wdata  : write data
//   o_rdata  : read data at i_idx (combinational)
// ---------------------------------------------------------------------------
module dmem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the CPU's MEM stage. One request is
// accepted at a time; the pipeline is held with stall_o for LATENCY+1 cycles,
// after which the store is committed or the load data is returned together
// with a single-cycle ack_o.
//   clk_i    : clock
//   rst_i    : asynchronous active-low reset
//   req_i    : access request, held stable by the CPU while stall_o is high
//   we_i     : 1 = store, 0 = load
//   addr_i   : byte address (word index taken from addr_i[IDX_W+1:2])
//   wdata_i  : store data
//   stall_o  : pipeline hold (combinational)
//   ack_o    : access complete, registered one-cycle pulse
//   rdata_o  : load data (store data on a store), registered
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
   parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic              ack_o,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = dmem_cnt_width(LATENCY);

   // FSM and counter
   dmem_state_t       r_state;
   dmem_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_accept;
   logic              w_commit;

   // Latched request
   logic              r_we;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdata;

   // Response registers
   logic              r_ack;
   logic [DATA_W-1:0] r_rdata;

   // Storage interface
   logic              w_mem_we;
   logic [DATA_W-1:0] w_mem_rdata;

   // Byte-offset and upper address bits are deliberately dropped: word-only
   // accesses, and out-of-range addresses wrap modulo DEPTH.
   logic              w_unused_addr;
   assign w_unused_addr = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (req_i) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = CNT_W'(LATENCY - 1);
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_commit    = 1'b1;
               w_state_nxt = DONE;
            end
         end
         // A req_i still high here belongs to the access being acknowledged.
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request latches: captured only on accept, so anything the CPU does to
   // the request lines during BUSY has no effect on the access in flight.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= we_i;
         r_idx   <= addr_i[IDX_W+1:2];
         r_wdata <= wdata_i;
      end
   end

   // ------------------------------------------------------------------------
   // Response registers: ack pulses in the DONE cycle that follows commit.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= w_commit;
         if (w_commit) begin
            r_rdata <= r_we ? r_wdata : w_mem_rdata;
         end
      end
   end

   // Reset forces IDLE asynchronously, so a pending store never reaches here.
   assign w_mem_we = w_commit & r_we;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .i_we    (w_mem_we),
      .i_idx   (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata)
   );

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign stall_o = ((r_state == IDLE) & req_i) | (r_state == BUSY);
   assign ack_o   = r_ack;
   assign rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int unsigned LAT = 4;
   localparam int unsigned DEP = 32;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        ack;
   logic [31:0] rdata;

   int          errors   = 0;
   int          checks   = 0;
   int          ack_seen = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [DEP];

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .DEPTH   (DEP),
      .LATENCY (LAT)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .stall_o (stall),
      .ack_o   (ack),
      .rdata_o (rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned idx_of(input logic [31:0] a);
      return (a / 4) % DEP;
   endfunction

   // Monitor: every acknowledged access must match the oldest expected response.
   always @(negedge clk) begin
      if (rst_i && ack) begin
         ack_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
         end else begin
            check("rdata", rdata, exp_q.pop_front());
         end
         check("stall_in_done", 32'(stall), 32'd0);
      end
   end

   // Called just after a rising edge; returns at the falling edge of DONE.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit perturb);
      int          n;
      logic [31:0] e;
      e = w ? d : model[idx_of(a)];
      if (w) model[idx_of(a)] = d;
      exp_q.push_back(e);
      we    = w;
      addr  = a;
      wdata = d;
      req   = 1'b1;
      n     = 0;
      @(negedge clk);
      while (stall && n < 20) begin
         n++;
         if (perturb && n == 2) begin
            addr  = $urandom;
            wdata = $urandom;
            we    = ~w;
            req   = 1'b0;
         end
         @(negedge clk);
      end
      check("stall_cycles", 32'(n), 32'(LAT + 1));
      check("ack_in_done", 32'(ack), 32'd1);
   endtask

   task automatic release_req();
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acks0;
      int          stray;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;

      rst_i = 1'b0;
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;

      // Reset state
      #12;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_stall_lo", 32'(stall), 32'd0);
      req = 1'b1;
      #1;
      check("rst_stall_hi", 32'(stall), 32'd1);
      req = 1'b0;
      #1;
      @(negedge clk);
      rst_i = 1'b1;
      stray = 0;
      repeat (3) begin
         @(negedge clk);
         if (stall || ack) stray++;
      end
      check("idle_after_rst", 32'(stray), 32'd0);
      @(posedge clk);
      #1;

      // Initialise every word so later random loads have defined data.
      for (int i = 0; i < int'(DEP); i++) begin
         issue(1'b1, 32'(i * 4), $urandom, 1'b0);
         release_req();
      end

      // Store then load
      issue(1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
      release_req();
      issue(1'b0, 32'h08, 32'h0, 1'b0);
      release_req();

      // Wrap-around and ignored byte offset
      issue(1'b1, 32'h84, 32'h11111111, 1'b0);
      release_req();
      issue(1'b0, 32'h04, 32'h0, 1'b0);
      release_req();
      issue(1'b0, 32'h07, 32'h0, 1'b0);
      release_req();

      // Request perturbation during BUSY
      issue(1'b1, 32'h20, 32'hCAFEF00D, 1'b1);
      release_req();
      issue(1'b0, 32'h20, 32'h0, 1'b0);
      release_req();
      issue(1'b0, 32'h24, 32'h0, 1'b1);
      release_req();

      // Reset mid-store: prior value 0, rdata holds a non-zero load result.
      issue(1'b1, 32'h10, 32'h0, 1'b0);
      release_req();
      issue(1'b0, 32'h08, 32'h0, 1'b0);
      release_req();
      we    = 1'b1;
      addr  = 32'h10;
      wdata = 32'hA5A5A5A5;
      req   = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      req   = 1'b0;
      #1;
      check("midrst_ack", 32'(ack), 32'd0);
      check("midrst_rdata", rdata, 32'd0);
      check("midrst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_i = 1'b1;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack) stray++;
      end
      check("midrst_no_ack", 32'(stray), 32'd0);
      @(posedge clk);
      #1;
      issue(1'b0, 32'h10, 32'h0, 1'b0);
      release_req();

      // Back-to-back loads with req held high through DONE
      acks0 = ack_seen;
      issue(1'b0, 32'h08, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      issue(1'b0, 32'h84, 32'h0, 1'b0);
      release_req();
      repeat (3) @(negedge clk);
      check("b2b_acks", 32'(ack_seen - acks0), 32'd2);
      @(posedge clk);
      #1;

      // Randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(1, 0));
         a = $urandom;
         d = $urandom;
         issue(w, a, d, ($urandom_range(3, 0) == 0));
         if ($urandom_range(1, 0) == 1) begin
            release_req();
         end else begin
            @(posedge clk);
            #1;
         end
      end
      release_req();

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the pipelined CPU's MEM-stage load/store requests. It accepts one request at a time, holds the pipeline with `stall_o` for a fixed access latency, then commits the write or returns read data with a one-cycle `ack_o`. It replaces the single-cycle data memory on the CPU's data port and models realistic off-core memory timing for hazard and stall verification.

## Interface

Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, word width.
- `DEPTH`, 32, number of words; power of two; `IDX_W = log2(DEPTH)`.
- `LATENCY`, 4, BUSY cycles per access; must be ≥1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `req_i`  in  1  access request. The CPU holds this and all request fields stable while `stall_o`=1.
- `we_i`  in  1  1 = store, 0 = load.
- `addr_i`  in  ADDR_W  byte address.
- `wdata_i`  in  DATA_W  store data.
- `stall_o`  out  1  pipeline hold; combinational.
- `ack_o`  out  1  access complete; registered, one-cycle pulse.
- `rdata_o`  out  DATA_W  load data; registered.

## Operation

- FSM states are IDLE, BUSY and DONE. Reset value is IDLE.
- **IDLE**
  - If `req_i`=1, latch `addr_i`, `we_i` and `wdata_i`.
  - Load `cnt` with LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the access on the latched fields and go to DONE.
    - Store: `mem[idx]` ← `wdata`, and `rdata_o` ← `wdata`.
    - Load: `rdata_o` ← `mem[idx]`.
- **DONE**
  - `ack_o`=1 for this single cycle.
  - Go to IDLE unconditionally. Any `req_i` seen in DONE is the request being acknowledged, not a new one.
- **Address mapping**
  - `idx` = `addr[IDX_W+1:2]`.
  - `addr[1:0]` is ignored; only word accesses are supported.
  - Upper address bits are discarded, so out-of-range addresses wrap modulo DEPTH.
- **Outputs**
  - `stall_o` = (state==IDLE & `req_i`) | (state==BUSY). It is low in DONE.
  - `ack_o` = 1 only in DONE.
  - `rdata_o` holds its last value until the next completion.
- **Boundary conditions**
  - Changes on `req_i` or the request fields during BUSY are ignored; the latched request completes.
  - If `req_i` drops mid-access, the access still completes and `ack_o` still pulses.
  - `rst_i` low mid-access:
    - Immediately force IDLE, `ack_o`=0, `rdata_o`=0 and `cnt`=0.
    - A pending store is discarded; `mem` is unchanged.
  - `mem` is not reset; contents are undefined until written.

## Timing

- Reset values:
  - state=IDLE, `cnt`=0, `ack_o`=0, `rdata_o`=0.
  - `stall_o` = `req_i` (combinational).
- Accept cycle is T0, with state IDLE and `req_i`=1.
- Cycles T1…T_LATENCY are BUSY. The memory access takes effect at the edge ending T_LATENCY.
- Cycle T_LATENCY+1 is DONE: `ack_o`=1, `rdata_o` valid, `stall_o`=0.
- `stall_o` is high for exactly LATENCY+1 cycles per access (T0…T_LATENCY).
- Back-to-back: a new request can be accepted at T_LATENCY+2. Throughput is one access per LATENCY+2 cycles.
- Store-then-load to the same index returns the stored data; there is no forwarding hazard because accesses are serialized.

## Structure

- Shared package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, BUSY, DONE};
  - `DMEM_LATENCY_DEFAULT`;
  - `DMEM_DEPTH_DEFAULT`.
- Sub-module `dmem_array`:
  - synchronous-write, combinational-read storage of DEPTH×DATA_W;
  - ports: clock, write enable, index, write data, read data.
- The FSM, counter and request latches stay in `dmem_responder`.

## Test plan

- **Reset state:** `rst_i`=0 → `ack_o`=0, `rdata_o`=0, `stall_o` tracks `req_i`. After release with no request, the state stays IDLE.
- **Store then load (LATENCY=4):**
  - Store `addr`=0x08, `wdata`=0xDEADBEEF → `stall_o` high 5 cycles; `ack_o` pulses at T5.
  - Then load `addr`=0x08 → `rdata_o`=0xDEADBEEF with `ack_o`.
- **Wrap-around (DEPTH=32):** store 0x11111111 to `addr`=0x84 → a load from 0x04 returns 0x11111111; `addr[1:0]`=2'b11 gives the same result.
- **Request perturbation:** during BUSY, change `addr_i`/`wdata_i` and drop `req_i` → the original latched access completes, `ack_o` pulses once, and the memory holds the original data.
- **Reset mid-store:** store 0xA5A5A5A5 to 0x10 over the prior value 0x0; assert `rst_i` at T2 → no `ack_o`; a later load from 0x10 returns 0x0.
- **Back-to-back loads with `req_i` held high:** two accesses complete at T5 and T11 (LATENCY=4); exactly two `ack_o` pulses, with no double-accept in the DONE cycle.
